// File: rtl/rgb_ctrl_pkg.sv
// rgb_ctrl_pkg: selection codes, FSM state type and quadrature step patterns for the RGB channel controller
package rgb_ctrl_pkg;
  typedef logic [1:0] state_t;
  localparam state_t SEL_R    = 2'd0;
  localparam state_t SEL_G    = 2'd1;
  localparam state_t SEL_B    = 2'd2;
  localparam state_t SEL_LOCK = 2'd3;
  // Patterns on {a, a_prev, b, b_prev}
  localparam logic [3:0] STEP_UP_A_RISE = 4'b1000;
  localparam logic [3:0] STEP_UP_A_FALL = 4'b0111;
  localparam logic [3:0] STEP_DN_B_RISE = 4'b0010;
  localparam logic [3:0] STEP_DN_B_FALL = 4'b1101;
  function automatic state_t next_sel(input state_t s);
    return s == SEL_B ? SEL_R : s + 2'd1;
  endfunction
endpackage

// File: rtl/quad_step.sv
// quad_step: synchronises encoder phases and emits registered 1-cycle up/dn step pulses
//  ports: clk, reset (async, active-high), enc_a/enc_b (async pins), up/dn (step pulses)
module quad_step
  import rgb_ctrl_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic enc_a,
  input  logic enc_b,
  output logic up,
  output logic dn
);
  logic a_s1, a_s2, b_s1, b_s2, a_prev, b_prev;
  logic [1:0] warm;
  logic [3:0] pat;
  assign pat = {a_s2, a_prev, b_s2, b_prev};
  // warm suppresses decode for three edges after reset so pins already high do not look like edges
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      {a_s1, a_s2, b_s1, b_s2, a_prev, b_prev} <= '0;
      warm <= '0;
      up <= 1'b0;
      dn <= 1'b0;
    end else begin
      {a_s1, a_s2} <= {enc_a, a_s1};
      {b_s1, b_s2} <= {enc_b, b_s1};
      {a_prev, b_prev} <= {a_s2, b_s2};
      warm <= warm == 2'd3 ? warm : warm + 2'd1;
      up <= warm == 2'd3 && (pat == STEP_UP_A_RISE || pat == STEP_UP_A_FALL);
      dn <= warm == 2'd3 && (pat == STEP_DN_B_RISE || pat == STEP_DN_B_FALL);
    end
endmodule

// File: rtl/rgb_channel_ctrl.sv
// rgb_channel_ctrl: one encoder plus one button adjust three colour channel registers
//  ports: clk, reset (async, active-high), enc_a/enc_b/btn (async pins),
//         red/green/blue (channel values), sel (0=R 1=G 2=B 3=locked), update (value-changed pulse)
module rgb_channel_ctrl
  import rgb_ctrl_pkg::*;
#(
  parameter int WIDTH           = 8,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int IDLE_CYCLES     = 1000,
  parameter bit SATURATE        = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enc_a,
  input  logic             enc_b,
  input  logic             btn,
  output logic [WIDTH-1:0] red,
  output logic [WIDTH-1:0] green,
  output logic [WIDTH-1:0] blue,
  output logic [1:0]       sel,
  output logic             update
);
  localparam int DW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int IW = $clog2(IDLE_CYCLES + 1) + 1;
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [IW-1:0] IDLE_LAST = IW'(IDLE_CYCLES - 1);
  localparam logic [WIDTH-1:0] MAX = '1;
  logic up, dn, step, press, lock, apply;
  logic btn_s1, btn_s2, btn_state;
  logic [DW-1:0] db_cnt;
  logic [IW-1:0] idle;
  state_t state, last_sel;
  logic [WIDTH-1:0] cur, nxt;
  quad_step u_quad (
    .clk  (clk),
    .reset(reset),
    .enc_a(enc_a),
    .enc_b(enc_b),
    .up   (up),
    .dn   (dn)
  );
  assign sel = state;
  assign step = up | dn;
  // press fires in the cycle the debounced level is accepted as high
  assign press = btn_s2 && !btn_state && db_cnt == DB_LAST;
  assign lock = IDLE_CYCLES != 0 && state != SEL_LOCK && idle == IDLE_LAST && !press && !step;
  assign apply = step && state != SEL_LOCK;
  always_comb begin
    cur = state == SEL_G ? green : state == SEL_B ? blue : red;
    nxt = up ? ((SATURATE && cur == MAX) ? cur : cur + WIDTH'(1)) :
          dn ? ((SATURATE && cur == '0) ? cur : cur - WIDTH'(1)) : cur;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      {btn_s1, btn_s2, btn_state} <= '0;
      db_cnt <= '0;
    end else begin
      {btn_s1, btn_s2} <= {btn, btn_s1};
      btn_state <= (btn_s2 != btn_state && db_cnt == DB_LAST) ? btn_s2 : btn_state;
      db_cnt <= (btn_s2 == btn_state || db_cnt == DB_LAST) ? '0 : db_cnt + DW'(1);
    end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= SEL_R;
      last_sel <= SEL_R;
      idle <= '0;
    end else begin
      state <= press ? (state == SEL_LOCK ? last_sel : next_sel(state)) : lock ? SEL_LOCK : state;
      last_sel <= lock ? state : last_sel;
      idle <= (press || step || lock || state == SEL_LOCK) ? '0 : idle + IW'(1);
    end
  // the step uses the pre-press selection because state only changes at this same edge
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      red <= '0;
      green <= '0;
      blue <= '0;
      update <= 1'b0;
    end else begin
      red <= (apply && state == SEL_R) ? nxt : red;
      green <= (apply && state == SEL_G) ? nxt : green;
      blue <= (apply && state == SEL_B) ? nxt : blue;
      update <= apply && nxt != cur;
    end
endmodule
